// File: rtl/cpu_pkg.sv
// Shared CPU constants: ROB geometry, requester indices and CDB arbiter sizing.
// Also holds the small helpers the arbiter uses.
package cpu_pkg;

    localparam int NUM_REQ   = 4;
    localparam int ROB_DEPTH = 16;
    localparam int ROB_IDX_W = 6;
    localparam int DATA_W    = 32;
    localparam int PTR_W     = $clog2(NUM_REQ);

    localparam logic [ROB_IDX_W-1:0] INVALID_ROB = 6'b010000;

    localparam int REQ_ADD   = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_BNE   = 2;
    localparam int REQ_STORE = 3;

    function automatic logic rob_ok(input logic [ROB_IDX_W-1:0] rob);
        return rob < ROB_IDX_W'(ROB_DEPTH);
    endfunction

    // Wraps explicitly so a non power-of-two NUM_REQ still works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side handshake and CDB broadcast bundle of the CDB arbiter.
// The master side covers the functional units and the ROB/RS consumers.
interface cdb_arbiter_if import cpu_pkg::*; ();

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*ROB_IDX_W-1:0] req_rob;
    logic [NUM_REQ*DATA_W-1:0]    req_data;
    logic [NUM_REQ-1:0]           req_ready;
    logic [1:0]                   cdb_valid;
    logic [2*ROB_IDX_W-1:0]       cdb_rob;
    logic [2*DATA_W-1:0]          cdb_data;
    logic                         bad_idx;

    modport slave (
        input  req_valid, req_rob, req_data,
        output req_ready, cdb_valid, cdb_rob, cdb_data, bad_idx
    );

    modport master (
        output req_valid, req_rob, req_data,
        input  req_ready, cdb_valid, cdb_rob, cdb_data, bad_idx
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick2.sv
// Stateless round-robin picker: rotates from ptr and returns the first two
// valid requesters as one-hot grants, port 0 being the closer one.
module rr_pick2 import cpu_pkg::*; (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt0,
    output logic [NUM_REQ-1:0] gnt1,
    output logic               found0,
    output logic               found1
);

    logic [PTR_W-1:0] idx;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the loop can leave a value unassigned and infer a latch.
    always_comb begin
        gnt0   = '0;
        gnt1   = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (valid[idx]) begin
                if (!found0) begin
                    gnt0[idx] = 1'b1;
                    found0    = 1'b1;
                end else if (!found1) begin
                    gnt1[idx] = 1'b1;
                    found1    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the ROB's two CDB write ports among the functional units: round-robin
// pick of two, same-rob_num conflict hold-off, registered broadcast, flush mask.
module cdb_arbiter import cpu_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);

    logic [PTR_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]   gnt0, gnt1;
    logic                 found0, found1;
    logic [ROB_IDX_W-1:0] rob0, rob1;
    logic [DATA_W-1:0]    data0, data1;
    logic [PTR_W-1:0]     idx0, idx1;
    logic                 conflict, grant_en, take0, take1, send0, send1;

    logic [1:0]             cdb_valid_q;
    logic [2*ROB_IDX_W-1:0] cdb_rob_q;
    logic [2*DATA_W-1:0]    cdb_data_q;
    logic                   bad_idx_q;

    rr_pick2 u_pick (
        .valid  (bus.req_valid),
        .ptr    (rr_ptr),
        .gnt0   (gnt0),
        .gnt1   (gnt1),
        .found0 (found0),
        .found1 (found1)
    );

    // One-hot to index/payload; grants are exclusive so plain selection is safe.
    always_comb begin
        rob0  = '0;
        rob1  = '0;
        data0 = '0;
        data1 = '0;
        idx0  = '0;
        idx1  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt0[i]) begin
                rob0  = bus.req_rob[i*ROB_IDX_W +: ROB_IDX_W];
                data0 = bus.req_data[i*DATA_W +: DATA_W];
                idx0  = PTR_W'(i);
            end
            if (gnt1[i]) begin
                rob1  = bus.req_rob[i*ROB_IDX_W +: ROB_IDX_W];
                data1 = bus.req_data[i*DATA_W +: DATA_W];
                idx1  = PTR_W'(i);
            end
        end
    end

    assign conflict = found1 && (rob1 == rob0);
    assign grant_en = !rst && !flush;
    assign take0    = grant_en && found0;
    assign take1    = grant_en && found1 && !conflict;
    assign send0    = take0 && rob_ok(rob0);
    assign send1    = take1 && rob_ok(rob1);

    assign bus.req_ready = (take0 ? gnt0 : '0) | (take1 ? gnt1 : '0);

    // NOTE: state is updated with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cdb_valid_q <= '0;
            cdb_rob_q   <= {INVALID_ROB, INVALID_ROB};
            cdb_data_q  <= '0;
            bad_idx_q   <= 1'b0;
        end else begin
            if (take1)      rr_ptr <= ptr_inc(idx1);
            else if (take0) rr_ptr <= ptr_inc(idx0);

            cdb_valid_q <= {send1, send0};
            cdb_rob_q   <= {send1 ? rob1 : INVALID_ROB, send0 ? rob0 : INVALID_ROB};
            if (send0) cdb_data_q[0 +: DATA_W]      <= data0;
            if (send1) cdb_data_q[DATA_W +: DATA_W] <= data1;

            if ((take0 && !rob_ok(rob0)) || (take1 && !rob_ok(rob1)))
                bad_idx_q <= 1'b1;
        end
    end

    // A broadcast registered before the flush must not reach the ROB.
    assign bus.cdb_valid = cdb_valid_q & {2{~flush}};
    assign bus.cdb_rob   = cdb_rob_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.bad_idx   = bad_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed test of cdb_arbiter: reset, round-robin, conflict, invalid index,
// wrap-around, flush masking and mid-run reset.
module tb_cdb_arbiter;
    import cpu_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   checks   = 0;
    int   failures = 0;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [ROB_IDX_W-1:0] rob, input logic [DATA_W-1:0] data);
        bus.req_rob[i*ROB_IDX_W +: ROB_IDX_W] = rob;
        bus.req_data[i*DATA_W +: DATA_W]      = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_rob   = '0;
        bus.req_data  = '0;
        set_req(0, 6'd1, 32'hA0);
        set_req(1, 6'd2, 32'hA1);
        set_req(2, 6'd3, 32'hA2);
        set_req(3, 6'd4, 32'hA3);

        // Reset held two cycles with every requester valid
        repeat (2) begin
            tick();
            check("rst_ready", bus.req_ready, 4'b0000);
        end
        check("rst_cdb_valid", bus.cdb_valid, 2'b00);
        check("rst_cdb_rob", bus.cdb_rob, 12'h410);
        check("rst_cdb_data", bus.cdb_data, 64'h0);
        check("rst_bad_idx", bus.bad_idx, 1'b0);
        check("rst_rr_ptr", dut.rr_ptr, 2'd0);

        // Round-robin over four valid requesters
        rst = 1'b0;
        #1;
        check("rr1_ready", bus.req_ready, 4'b0011);
        tick();
        check("rr1_valid", bus.cdb_valid, 2'b11);
        check("rr1_rob", bus.cdb_rob, {6'd2, 6'd1});
        check("rr1_data0", bus.cdb_data[31:0], 32'hA0);
        check("rr1_data1", bus.cdb_data[63:32], 32'hA1);
        check("rr1_ptr", dut.rr_ptr, 2'd2);
        check("rr2_ready", bus.req_ready, 4'b1100);
        tick();
        check("rr2_valid", bus.cdb_valid, 2'b11);
        check("rr2_rob", bus.cdb_rob, {6'd4, 6'd3});
        check("rr2_data0", bus.cdb_data[31:0], 32'hA2);
        check("rr2_data1", bus.cdb_data[63:32], 32'hA3);
        check("rr2_ptr", dut.rr_ptr, 2'd0);

        // Same rob_num on req0 and req1: req1 deferred one cycle
        bus.req_valid = 4'b0011;
        set_req(0, 6'd5, 32'hB0);
        set_req(1, 6'd5, 32'hB1);
        #1;
        check("cf1_ready", bus.req_ready, 4'b0001);
        tick();
        check("cf1_valid", bus.cdb_valid, 2'b01);
        check("cf1_rob", bus.cdb_rob, {INVALID_ROB, 6'd5});
        check("cf1_data0", bus.cdb_data[31:0], 32'hB0);
        check("cf1_data1_hold", bus.cdb_data[63:32], 32'hA3);
        check("cf1_ptr", dut.rr_ptr, 2'd1);
        bus.req_valid = 4'b0010;
        #1;
        check("cf2_ready", bus.req_ready, 4'b0010);
        tick();
        check("cf2_valid", bus.cdb_valid, 2'b01);
        check("cf2_rob", bus.cdb_rob, {INVALID_ROB, 6'd5});
        check("cf2_data0", bus.cdb_data[31:0], 32'hB1);
        check("cf2_ptr", dut.rr_ptr, 2'd2);

        // Out-of-range rob_num: consumed, not broadcast, sticky error
        bus.req_valid = 4'b0100;
        set_req(2, 6'd20, 32'hD2);
        #1;
        check("bad_ready", bus.req_ready, 4'b0100);
        tick();
        check("bad_valid", bus.cdb_valid, 2'b00);
        check("bad_rob", bus.cdb_rob, 12'h410);
        check("bad_flag", bus.bad_idx, 1'b1);
        check("bad_data0_hold", bus.cdb_data[31:0], 32'hB1);
        check("bad_ptr", dut.rr_ptr, 2'd3);
        bus.req_valid = 4'b0000;
        tick();
        check("bad_sticky", bus.bad_idx, 1'b1);
        check("idle_valid", bus.cdb_valid, 2'b00);
        check("idle_ptr_hold", dut.rr_ptr, 2'd3);

        // Wrap from rr_ptr=3: req3 on port 0, req0 on port 1
        bus.req_valid = 4'b1001;
        set_req(3, 6'd9, 32'hC3);
        set_req(0, 6'd8, 32'hC0);
        #1;
        check("wrap_ready", bus.req_ready, 4'b1001);
        tick();
        check("wrap_valid", bus.cdb_valid, 2'b11);
        check("wrap_rob", bus.cdb_rob, {6'd8, 6'd9});
        check("wrap_data0", bus.cdb_data[31:0], 32'hC3);
        check("wrap_data1", bus.cdb_data[63:32], 32'hC0);
        check("wrap_ptr", dut.rr_ptr, 2'd1);

        // Grant req0 (rob 7), then flush the following cycle
        bus.req_valid = 4'b0001;
        set_req(0, 6'd7, 32'hE0);
        #1;
        check("fl_grant_ready", bus.req_ready, 4'b0001);
        tick();
        check("fl_pre_valid", bus.cdb_valid, 2'b01);
        check("fl_pre_rob", bus.cdb_rob, {INVALID_ROB, 6'd7});
        flush         = 1'b1;
        bus.req_valid = 4'b0011;
        set_req(1, 6'd10, 32'hE1);
        #1;
        check("fl_mask_valid", bus.cdb_valid, 2'b00);
        check("fl_ready", bus.req_ready, 4'b0000);
        tick();
        flush = 1'b0;
        #1;
        check("fl_next_valid", bus.cdb_valid, 2'b00);
        check("fl_ptr_hold", dut.rr_ptr, 2'd1);
        check("fl_after_ready", bus.req_ready, 4'b0011);

        // Reset mid-operation drops the pending grant and clears sticky state
        rst = 1'b1;
        tick();
        check("mr_valid", bus.cdb_valid, 2'b00);
        check("mr_rob", bus.cdb_rob, 12'h410);
        check("mr_bad", bus.bad_idx, 1'b0);
        check("mr_ptr", dut.rr_ptr, 2'd0);
        check("mr_ready", bus.req_ready, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
